// File: rtl/receive_mailbox.sv
// receive_mailbox: drains the receive queue into one single-entry slot per
// sender core and serves specific-sender or round-robin receive requests.
module receive_mailbox #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = 2,
    parameter int unsigned DATA_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              rq_valid,
    output logic              rq_ready,
    input  logic [SRC_W-1:0]  rq_source,
    input  logic [DATA_W-1:0] rq_payload,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_any,
    input  logic [SRC_W-1:0]  req_source,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [SRC_W-1:0]  resp_source,
    output logic [DATA_W-1:0] resp_payload,
    output logic [NUM_SRC-1:0] occupancy
);

    localparam logic [SRC_W:0] NUM_SRC_W = (SRC_W+1)'(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [NUM_SRC-1:0]  full;
    logic [DATA_W-1:0]   slot_data [NUM_SRC];
    logic                lat_any;
    logic [SRC_W-1:0]    lat_src;
    logic [SRC_W-1:0]    rr_ptr;

    logic                hit;
    logic [SRC_W-1:0]    sel;
    logic [SRC_W:0]      scan_sum;
    logic [SRC_W:0]      sel_inc;
    logic [SRC_W-1:0]    rr_next;

    // Handshake readies: slot availability uses the pre-clear full bit
    assign rq_ready  = ~flush & ~full[rq_source];
    assign req_ready = ~flush & (state == IDLE);
    assign occupancy = full;

    // Slot selection for the latched request: specific slot or first full slot from rr_ptr
    always_comb begin
        hit      = 1'b0;
        sel      = lat_src;
        scan_sum = '0;
        if (lat_any) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
                if (scan_sum >= NUM_SRC_W) begin
                    scan_sum = scan_sum - NUM_SRC_W;
                end
                if (!hit && full[scan_sum[SRC_W-1:0]]) begin
                    hit = 1'b1;
                    sel = scan_sum[SRC_W-1:0];
                end
            end
        end else begin
            hit = full[lat_src];
        end
    end

    // Round-robin pointer advances to the slot after the one served
    always_comb begin
        sel_inc = {1'b0, sel} + (SRC_W+1)'(1);
        if (sel_inc >= NUM_SRC_W) begin
            sel_inc = '0;
        end
        rr_next = sel_inc[SRC_W-1:0];
    end

    // Control FSM, slot full flags and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            full         <= '0;
            lat_any      <= 1'b0;
            lat_src      <= '0;
            rr_ptr       <= '0;
            resp_valid   <= 1'b0;
            resp_source  <= '0;
            resp_payload <= '0;
        end else if (flush) begin
            state      <= IDLE;
            full       <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_any <= req_any;
                        lat_src <= req_source;
                        state   <= MATCH;
                    end
                end
                MATCH, WAIT: begin
                    if (hit) begin
                        resp_valid   <= 1'b1;
                        resp_source  <= sel;
                        resp_payload <= slot_data[sel];
                        full[sel]    <= 1'b0;
                        if (lat_any) begin
                            rr_ptr <= rr_next;
                        end
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Never collides with the clear above: rq_ready requires the slot empty
            if (rq_valid && rq_ready) begin
                full[rq_source] <= 1'b1;
            end
        end
    end

    // Slot payload storage, written on an accepted inbound transfer
    always_ff @(posedge clk) begin
        if (!rst && rq_valid && rq_ready) begin
            slot_data[rq_source] <= rq_payload;
        end
    end

endmodule

// File: tb/tb_receive_mailbox.sv
// Bench for receive_mailbox: transaction-level mailbox model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_receive_mailbox;

    localparam int unsigned NS = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          rq_valid = 1'b0;
    logic          rq_ready;
    logic [SW-1:0] rq_source = '0;
    logic [DW-1:0] rq_payload = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_any = 1'b0;
    logic [SW-1:0] req_source = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [SW-1:0] resp_source;
    logic [DW-1:0] resp_payload;
    logic [NS-1:0] occupancy;

    receive_mailbox #(.NUM_SRC(NS), .SRC_W(SW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_source(rq_source), .rq_payload(rq_payload),
        .req_valid(req_valid), .req_ready(req_ready), .req_any(req_any), .req_source(req_source),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_source(resp_source),
        .resp_payload(resp_payload), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Mailbox model: slots, one outstanding request, one held response
    bit            armed = 1'b0;
    bit            m_full [NS];
    logic [DW-1:0] m_data [NS];
    int            m_rr;
    bit            m_req, m_any, m_resp;
    int            m_src;
    logic [SW-1:0] m_rsrc;
    logic [DW-1:0] m_rdata;
    logic [NS-1:0] m_occ;
    bit            m_acc, m_found;
    int            m_s;

    // Compare DUT outputs against the model, then advance the model one edge
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < int'(NS); k++) m_occ[k] = m_full[k];
            chk("rq_ready", 64'(rq_ready), 64'(!flush && !m_full[rq_source]));
            chk("req_ready", 64'(req_ready), 64'(!flush && !m_req && !m_resp));
            chk("resp_valid", 64'(resp_valid), 64'(m_resp));
            chk("resp_source", 64'(resp_source), 64'(m_rsrc));
            chk("resp_payload", resp_payload, m_rdata);
            chk("occupancy", 64'(occupancy), 64'(m_occ));
        end
        if (rst) begin
            for (int k = 0; k < int'(NS); k++) m_full[k] = 1'b0;
            m_rr = 0; m_req = 1'b0; m_resp = 1'b0; m_any = 1'b0; m_src = 0;
            m_rsrc = '0; m_rdata = '0;
            armed = 1'b1;
        end else if (armed && flush) begin
            for (int k = 0; k < int'(NS); k++) m_full[k] = 1'b0;
            m_req = 1'b0; m_resp = 1'b0;
        end else if (armed) begin
            m_acc = rq_valid && !m_full[rq_source];
            if (m_resp) begin
                if (resp_ready) m_resp = 1'b0;
            end else if (m_req) begin
                m_found = 1'b0; m_s = 0;
                if (m_any) begin
                    for (int k = 0; k < int'(NS); k++) begin
                        if (!m_found && m_full[(m_rr + k) % NS]) begin
                            m_found = 1'b1; m_s = (m_rr + k) % NS;
                        end
                    end
                end else begin
                    m_found = m_full[m_src]; m_s = m_src;
                end
                if (m_found) begin
                    m_resp = 1'b1; m_req = 1'b0;
                    m_rsrc = SW'(m_s); m_rdata = m_data[m_s];
                    m_full[m_s] = 1'b0;
                    if (m_any) m_rr = (m_s + 1) % NS;
                end
            end else if (req_valid) begin
                m_req = 1'b1; m_any = req_any; m_src = int'(req_source);
            end
            if (m_acc) begin
                m_full[rq_source] = 1'b1;
                m_data[rq_source] = rq_payload;
            end
        end
    end

    task automatic push(input logic [SW-1:0] s, input logic [DW-1:0] d, output int xc, output bit first_rdy);
        @(posedge clk); #1;
        rq_valid = 1'b1; rq_source = s; rq_payload = d; xc = -1; first_rdy = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) first_rdy = rq_ready;
            if (rq_ready) begin xc = cyc; break; end
        end
        @(posedge clk); #1;
        rq_valid = 1'b0;
        if (xc < 0) chk("push_timeout", 64'(1), 64'(0));
    endtask

    // Returns at the negedge of the first resp_valid cycle
    task automatic do_req(input bit a, input logic [SW-1:0] s, output int ac, output int rc,
                          output logic [SW-1:0] rs, output logic [DW-1:0] rd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_any = a; req_source = s; ac = -1; rc = -1; rs = '0; rd = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready) begin ac = cyc; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin rc = cyc; rs = resp_source; rd = resp_payload; break; end
        end
        if (ac < 0 || rc < 0) chk("req_timeout", 64'(1), 64'(0));
    endtask

    int            xc, xc2, ac, rc;
    bit            fr;
    logic [SW-1:0] rs;
    logic [DW-1:0] rd;
    logic [SW-1:0] exp_src [3];
    logic [DW-1:0] exp_dat [3];

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rq_ready", 64'(rq_ready), 64'(1));
        chk("reset_req_ready", 64'(req_ready), 64'(1));
        chk("reset_resp_valid", 64'(resp_valid), 64'(0));
        chk("reset_occupancy", 64'(occupancy), 64'(0));
        chk("reset_resp_payload", resp_payload, 64'(0));

        // Basic match
        push(2'd2, 64'hA5, xc, fr);
        do_req(1'b0, 2'd2, ac, rc, rs, rd);
        chk("basic_latency", 64'(rc - ac), 64'(2));
        chk("basic_source", 64'(rs), 64'(2));
        chk("basic_payload", rd, 64'hA5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("basic_occ_cleared", 64'(occupancy), 64'(0));

        // Wait-then-arrive
        fork
            do_req(1'b0, 2'd1, ac, rc, rs, rd);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("wait_req_ready_low", 64'(req_ready), 64'(0));
                push(2'd1, 64'h11, xc, fr);
            end
        join
        chk("wait_latency", 64'(rc - xc), 64'(2));
        chk("wait_payload", rd, 64'h11);

        // Head-of-line block on a full slot
        push(2'd0, 64'h20, xc, fr);
        fork
            push(2'd0, 64'h21, xc2, fr);
            begin
                repeat (3) @(posedge clk);
                do_req(1'b0, 2'd0, ac, rc, rs, rd);
            end
        join
        chk("hol_first_offer_blocked", 64'(fr), 64'(0));
        chk("hol_accept_after_clear", 64'(xc2 - ac), 64'(2));
        chk("hol_first_payload", rd, 64'h20);
        do_req(1'b0, 2'd0, ac, rc, rs, rd);
        chk("hol_second_payload", rd, 64'h21);

        // Round-robin any
        push(2'd0, 64'h10, xc, fr);
        push(2'd1, 64'h11, xc, fr);
        push(2'd3, 64'h13, xc, fr);
        exp_src[0] = 2'd0; exp_src[1] = 2'd1; exp_src[2] = 2'd3;
        exp_dat[0] = 64'h10; exp_dat[1] = 64'h11; exp_dat[2] = 64'h13;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 2'd0, ac, rc, rs, rd);
            chk("rr_source", 64'(rs), 64'(exp_src[i]));
            chk("rr_payload", rd, exp_dat[i]);
        end
        push(2'd2, 64'h32, xc, fr);
        push(2'd0, 64'h30, xc, fr);
        do_req(1'b1, 2'd0, ac, rc, rs, rd);
        chk("rr_wrap_source", 64'(rs), 64'(0));
        do_req(1'b1, 2'd0, ac, rc, rs, rd);
        chk("rr_next_source", 64'(rs), 64'(2));

        // Backpressure
        push(2'd1, 64'h77, xc, fr);
        resp_ready = 1'b0;
        do_req(1'b0, 2'd1, ac, rc, rs, rd);
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_valid", 64'(resp_valid), 64'(1));
            chk("bp_resp_source", 64'(resp_source), 64'(1));
            chk("bp_resp_payload", resp_payload, 64'h77);
            chk("bp_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_released", 64'(resp_valid), 64'(0));
        chk("bp_req_ready_back", 64'(req_ready), 64'(1));

        // Flush with a pending response; offered message must not land
        push(2'd2, 64'h42, xc, fr);
        push(2'd1, 64'h51, xc, fr);
        resp_ready = 1'b0;
        do_req(1'b0, 2'd1, ac, rc, rs, rd);
        @(posedge clk); #1;
        flush = 1'b1; rq_valid = 1'b1; rq_source = 2'd3; rq_payload = 64'h99;
        @(negedge clk);
        chk("flush_rq_ready", 64'(rq_ready), 64'(0));
        chk("flush_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; rq_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        chk("flush_occupancy", 64'(occupancy), 64'(0));
        chk("flush_resp_valid", 64'(resp_valid), 64'(0));
        push(2'd0, 64'h60, xc, fr);
        push(2'd3, 64'h63, xc, fr);
        do_req(1'b1, 2'd0, ac, rc, rs, rd);
        chk("flush_rr_kept", 64'(rs), 64'(3));
        do_req(1'b1, 2'd0, ac, rc, rs, rd);
        chk("flush_rr_wrap", 64'(rs), 64'(0));

        // Reset mid-operation
        push(2'd2, 64'h42, xc, fr);
        push(2'd1, 64'h51, xc, fr);
        resp_ready = 1'b0;
        do_req(1'b0, 2'd1, ac, rc, rs, rd);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_rq_ready", 64'(rq_ready), 64'(1));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_source", 64'(resp_source), 64'(0));
        chk("rst_resp_payload", resp_payload, 64'(0));
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        push(2'd3, 64'h73, xc, fr);
        push(2'd0, 64'h70, xc, fr);
        do_req(1'b1, 2'd0, ac, rc, rs, rd);
        chk("rst_rr_cleared", 64'(rs), 64'(0));
        do_req(1'b1, 2'd0, ac, rc, rs, rd);
        chk("rst_rr_next", 64'(rs), 64'(3));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/receive_mailbox.md
Name: receive_mailbox

Overview:
- Sits directly downstream of the receive queue. Drains queued inbound messages into one single-entry slot per sender core.
- Serves core-side receive requests for a specific sender or for any sender (round-robin) through a request/response handshake.
- Decouples message arrival order from the order in which software consumes them.

Parameters:
- NUM_SRC, 4, number of sender cores; one mailbox slot each.
- SRC_W, 2, width of a sender id; must equal clog2(NUM_SRC), minimum 1.
- DATA_W, 64, message payload width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all slots and any in-flight request.
- rq_valid  input  1  receive queue has a message.
- rq_ready  output  1  mailbox accepts the message this cycle.
- rq_source  input  SRC_W  sender id of the offered message.
- rq_payload  input  DATA_W  payload of the offered message.
- req_valid  input  1  core issues a receive request.
- req_ready  output  1  request accepted this cycle.
- req_any  input  1  1 = take from any sender; 0 = use req_source.
- req_source  input  SRC_W  requested sender id, when req_any = 0.
- resp_valid  output  1  response holds a message.
- resp_ready  input  1  core takes the response.
- resp_source  output  SRC_W  sender id of the returned message.
- resp_payload  output  DATA_W  returned payload.
- occupancy  output  NUM_SRC  per-slot full flags, for debug and status.

Behaviour:
- State: per-slot full bit and payload register; FSM state; latched request (any flag, source); round-robin pointer rr_ptr (SRC_W bits); response registers.
- Reset (rst = 1): all slots empty; FSM = IDLE; rr_ptr = 0.
  - Reset outputs: rq_ready = 1, req_ready = 1, resp_valid = 0, resp_source = 0, resp_payload = 0, occupancy = 0.
- Inbound side:
  - rq_ready = ~full[rq_source], combinational from current occupancy.
  - Transfer occurs when rq_valid & rq_ready. The slot becomes full next cycle with the payload.
  - A slot freed in cycle t accepts new data no earlier than cycle t+1; there is no same-cycle reuse.
  - A full slot blocks the queue head (head-of-line); other senders wait behind it. This is intended.
- FSM states:
  - IDLE: req_ready = 1. When req_valid is high, latch req_any and req_source, then go to MATCH.
  - MATCH: evaluate occupancy.
    - Specific request: go to RESP if full[src], otherwise go to WAIT.
    - Any request: select the first full slot scanning from rr_ptr upward with wrap; go to RESP if one exists, otherwise go to WAIT.
    - On a hit: copy the selected slot into the response registers, clear the slot, and set rr_ptr = selected + 1 (mod NUM_SRC; any-request only).
  - WAIT: re-evaluate every cycle with the same rules as MATCH. A message written into a slot in cycle t is visible from cycle t+1.
  - RESP: resp_valid = 1 and outputs are held stable. When resp_ready is high, go to IDLE.
  - req_ready = 0 in every state except IDLE.
- Latency: request accepted at t, slot already full → resp_valid at t+2. Minimum request-to-request spacing is 3 cycles with resp_ready held at 1.
- The slot clear (consumer) and the slot write (producer) never target the same slot in the same cycle, because rq_ready uses the pre-clear full bit.
- flush:
  - Highest priority after rst. Next cycle: all slots empty, FSM = IDLE, resp_valid = 0.
  - A response not yet taken is dropped. rr_ptr is preserved.
  - rq_ready and req_ready are forced to 0 during the flush cycle; no transfers occur.
- Reset mid-operation clears identically to power-on. Held or pending data is lost.
- resp_payload and resp_source are only meaningful while resp_valid = 1. They hold their last value otherwise.

Test Plan:
- Basic match: push src 2, payload 0xA5; then request specific src 2 → resp_valid 2 cycles after req accept, resp_source = 2, resp_payload = 0xA5, occupancy[2] returns to 0.
- Wait-then-arrive: request src 1 with all slots empty → FSM holds, req_ready = 0. Push src 1, payload 0x11 at t → resp_valid at t+2 with payload 0x11.
- Head-of-line block: push src 0 twice without consuming → rq_ready = 0 on the second offer. After a receive of src 0, the second message is accepted the cycle after the slot clears.
- Round-robin any: fill slots 0, 1, 3 (payloads 0x10, 0x11, 0x13). Issue three any-requests from rr_ptr = 0 → sources 0, 1, 3 in order; rr_ptr ends at 0.
- Backpressure: hold resp_ready = 0 for 5 cycles → resp_valid, resp_source and resp_payload stay stable, and req_ready stays 0 until the handshake completes.
- Flush/reset: with slot 2 full and a response pending, assert flush one cycle → next cycle occupancy = 0 and resp_valid = 0. Repeat the same setup with rst → all outputs at reset values.
